// File: rtl/dmem_store_queue_responder.sv
// RV32I data-memory responder: combinational loads, in-order store queue draining into a byte-enabled array,
// youngest-first store-to-load forwarding. Define DMEM_STATS_EN to add ld/st/fwd counters.
module dmem_store_queue_responder #(
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 32,
   parameter int MEM_WORDS = 128,
   parameter int SQ_DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      mem_read,
   input  logic                      mem_write,
   input  logic [ADDR_W-1:0]         addr,
   input  logic [DATA_W-1:0]         wr_data,
   input  logic [2:0]                funct3,
   input  logic                      flush,
   output logic [DATA_W-1:0]         rd_data,
   output logic [$clog2(SQ_DEPTH):0] sq_count,
   output logic                      sq_full,
   output logic                      flush_done,
   output logic                      misaligned
`ifdef DMEM_STATS_EN
   ,
   output logic [15:0]               ld_count,
   output logic [15:0]               st_count,
   output logic [15:0]               fwd_count
`endif
);
   localparam int PTR_W = $clog2(SQ_DEPTH);
   localparam int IDX_W = ADDR_W - 2;
   localparam logic [PTR_W:0] CNT_FULL = SQ_DEPTH[PTR_W:0];
   localparam logic [PTR_W:0] CNT_ONE  = 1;
   localparam logic [PTR_W-1:0] PTR_ONE = 1;

   logic [31:0]      mem_reg [MEM_WORDS];
   logic [IDX_W-1:0] sq_idx_reg  [SQ_DEPTH];
   logic [3:0]       sq_be_reg   [SQ_DEPTH];
   logic [31:0]      sq_data_reg [SQ_DEPTH];
   logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             misaligned_reg;

   logic             f3_valid, aligned, misalign_evt, store_ok, load_ok, drain, is_unsigned;
   logic [1:0]       size;
   logic [IDX_W-1:0] word_idx;
   logic [3:0]       acc_be;
   logic [31:0]      st_data, merged_word;
   logic [7:0]       sel_byte;
   logic [15:0]      sel_half;
`ifdef DMEM_STATS_EN
   logic [3:0]       lane_fwd;
`endif

   // funct3[1:0] is the access size (B/H/W), funct3[2] selects zero-extension
   always_comb begin
      size         = funct3[1:0];
      is_unsigned  = funct3[2];
      word_idx     = addr[ADDR_W-1:2];
      f3_valid     = (funct3[1:0] != 2'b11) && !(funct3[2] && funct3[1]);
      aligned      = (size == 2'd0) || (size == 2'd1 && !addr[0]) || (size == 2'd2 && addr[1:0] == 2'b00);
      misalign_evt = (mem_read || mem_write) && f3_valid && !aligned;
      store_ok     = mem_write && f3_valid && aligned;
      load_ok      = mem_read && !mem_write && f3_valid && aligned;
      acc_be       = 4'hF;
      st_data      = wr_data;
      case (size)
         2'd0: begin
            acc_be  = 4'b0001 << addr[1:0];
            st_data = {4{wr_data[7:0]}};
         end
         2'd1: begin
            acc_be  = 4'b0011 << addr[1:0];
            st_data = {2{wr_data[15:0]}};
         end
         default: ;
      endcase
      drain = (count_reg != '0) &&
              ((!mem_read && !mem_write) || flush || (store_ok && count_reg == CNT_FULL));
   end

   // Per lane: array byte, overridden by every matching valid entry from oldest to youngest
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_byte;
      logic       lane_hit;
      always_comb begin
         lane_byte = mem_reg[word_idx][8*gi +: 8];
         lane_hit  = 1'b0;
         for (int k = 0; k < SQ_DEPTH; k++) begin
            if (k < int'(count_reg) &&
                sq_idx_reg[rd_ptr_reg + k[PTR_W-1:0]] == word_idx &&
                sq_be_reg[rd_ptr_reg + k[PTR_W-1:0]][gi]) begin
               lane_byte = sq_data_reg[rd_ptr_reg + k[PTR_W-1:0]][8*gi +: 8];
               lane_hit  = 1'b1;
            end
         end
      end
      assign merged_word[8*gi +: 8] = lane_byte;
`ifdef DMEM_STATS_EN
      assign lane_fwd[gi] = lane_hit;
`else
      logic unused_hit;
      assign unused_hit = lane_hit;
`endif
   end

   always_comb begin
      sel_byte = merged_word[{addr[1:0], 3'b000} +: 8];
      sel_half = merged_word[{addr[1], 4'b0000} +: 16];
      rd_data  = '0;
      if (load_ok && !reset) begin
         case (size)
            2'd0:    rd_data = is_unsigned ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            2'd1:    rd_data = is_unsigned ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
            default: rd_data = merged_word;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_reg     <= '0;
         wr_ptr_reg     <= '0;
         count_reg      <= '0;
         misaligned_reg <= 1'b0;
         for (int i = 0; i < MEM_WORDS; i++) mem_reg[i] <= '0;
      end else begin
         if (misalign_evt) misaligned_reg <= 1'b1;
         if (drain) begin
            for (int b = 0; b < 4; b++) begin
               if (sq_be_reg[rd_ptr_reg][b])
                  mem_reg[sq_idx_reg[rd_ptr_reg]][8*b +: 8] <= sq_data_reg[rd_ptr_reg][8*b +: 8];
            end
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         if (store_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         case ({store_ok, drain})
            2'b10:   count_reg <= count_reg + CNT_ONE;
            2'b01:   count_reg <= count_reg - CNT_ONE;
            default: ;
         endcase
      end
   end

   // Queue payload needs no reset: entries are only visible while counted
   always_ff @(posedge clk) begin
      if (!reset && store_ok) begin
         sq_idx_reg[wr_ptr_reg]  <= word_idx;
         sq_be_reg[wr_ptr_reg]   <= acc_be;
         sq_data_reg[wr_ptr_reg] <= st_data;
      end
   end

   assign sq_count   = count_reg;
   assign sq_full    = (count_reg == CNT_FULL);
   assign flush_done = flush && (count_reg == '0);
   assign misaligned = misaligned_reg;

`ifdef DMEM_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         ld_count  <= '0;
         st_count  <= '0;
         fwd_count <= '0;
      end else begin
         if (load_ok && ld_count != 16'hFFFF) ld_count <= ld_count + 16'd1;
         if (store_ok && st_count != 16'hFFFF) st_count <= st_count + 16'd1;
         if (load_ok && |(lane_fwd & acc_be) && fwd_count != 16'hFFFF) fwd_count <= fwd_count + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_dmem_store_queue_responder.sv
// Bench for dmem_store_queue_responder: byte-addressed immediate-write memory model plus queue occupancy
// rules, checked every cycle, with directed scenarios pinned by literal expectations and a random phase.
module tb_dmem_store_queue_responder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, mem_read, mem_write, flush;
   logic [8:0]  addr;
   logic [31:0] wr_data;
   logic [2:0]  funct3;
   logic [31:0] rd_data;
   logic [2:0]  sq_count;
   logic        sq_full, flush_done, misaligned;

   dmem_store_queue_responder dut (
      .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
      .wr_data(wr_data), .funct3(funct3), .flush(flush), .rd_data(rd_data), .sq_count(sq_count),
      .sq_full(sq_full), .flush_done(flush_done), .misaligned(misaligned)
   );

   logic [7:0] amem [512];
   int  mcount;
   bit  mmis;
   bit  started;
   int  n_cmp, n_err;

   function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endfunction

   function automatic bit f3_ok(logic [2:0] f);
      return f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
   endfunction

   function automatic int nbytes(logic [2:0] f);
      return 1 << f[1:0];
   endfunction

   function automatic bit is_aligned(logic [2:0] f, logic [8:0] a);
      return (int'(a) % nbytes(f)) == 0;
   endfunction

   // Architectural view: loads see every accepted store immediately
   function automatic logic [31:0] exp_rd();
      logic [31:0] v;
      int n;
      v = '0;
      if (reset || !mem_read || mem_write || !f3_ok(funct3) || !is_aligned(funct3, addr)) return '0;
      n = nbytes(funct3);
      for (int i = 0; i < n; i++) v = v | (32'(amem[int'(addr) + i]) << (8 * i));
      if (!funct3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      return v;
   endfunction

   task automatic model_update();
      bit ok, st, drn;
      int n;
      if (reset) begin
         foreach (amem[i]) amem[i] = 8'h00;
         mcount = 0;
         mmis   = 1'b0;
      end else begin
         ok  = f3_ok(funct3) && is_aligned(funct3, addr);
         if ((mem_read || mem_write) && f3_ok(funct3) && !is_aligned(funct3, addr)) mmis = 1'b1;
         st  = mem_write && ok;
         drn = (mcount > 0) && ((!mem_read && !mem_write) || flush || (st && mcount == 4));
         if (st) begin
            n = nbytes(funct3);
            for (int i = 0; i < n; i++) amem[int'(addr) + i] = wr_data[8*i +: 8];
         end
         mcount = mcount + int'(st) - int'(drn);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         check("rd_data", rd_data, exp_rd());
         check("sq_count", 32'(sq_count), 32'(mcount));
         check("sq_full", 32'(sq_full), 32'(mcount == 4));
         check("flush_done", 32'(flush_done), 32'(flush && mcount == 0));
         check("misaligned", 32'(misaligned), 32'(mmis));
      end
   end

   task automatic drive(bit r, bit w, logic [8:0] a, logic [31:0] d, logic [2:0] f, bit fl, bit rst);
      mem_read = r; mem_write = w; addr = a; wr_data = d; funct3 = f; flush = fl; reset = rst;
      #3;
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 9'h0, 32'h0, 3'b010, 0, 0);
         tick();
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0; started = 1'b0; mcount = 0; mmis = 1'b0;
      drive(0, 0, 9'h0, 32'h0, 3'b010, 0, 1); tick();
      started = 1'b1;
      drive(0, 0, 9'h0, 32'h0, 3'b010, 0, 1); tick();
      drive(0, 0, 9'h0, 32'h0, 3'b010, 0, 0);
      check("rst_count", 32'(sq_count), 32'd0);
      check("rst_full", 32'(sq_full), 32'd0);
      check("rst_mis", 32'(misaligned), 32'd0);
      check("rst_rd", rd_data, 32'd0);
      tick();

      // 1: forwarded then drained word
      drive(0, 1, 9'h010, 32'hDEADBEEF, 3'b010, 0, 0); tick();
      drive(1, 0, 9'h010, 32'h0, 3'b010, 0, 0);
      check("t1_lw_fwd", rd_data, 32'hDEADBEEF);
      check("t1_cnt1", 32'(sq_count), 32'd1);
      tick();
      idle(1);
      drive(1, 0, 9'h010, 32'h0, 3'b010, 0, 0);
      check("t1_cnt0", 32'(sq_count), 32'd0);
      check("t1_lw_mem", rd_data, 32'hDEADBEEF);
      tick();

      // 2: byte store merged into queued word
      drive(0, 1, 9'h010, 32'h0, 3'b010, 0, 0); tick();
      drive(0, 1, 9'h013, 32'h80, 3'b000, 0, 0); tick();
      drive(1, 0, 9'h013, 32'h0, 3'b000, 0, 0); check("t2_lb", rd_data, 32'hFFFFFF80); tick();
      drive(1, 0, 9'h013, 32'h0, 3'b100, 0, 0); check("t2_lbu", rd_data, 32'h00000080); tick();
      drive(1, 0, 9'h010, 32'h0, 3'b010, 0, 0); check("t2_lw", rd_data, 32'h80000000); tick();
      idle(4);

      // 3: back-to-back stores saturate the queue without blocking
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, 9'(i * 4), 32'(i + 1), 3'b010, 0, 0);
         tick();
         check("t3_cnt", 32'(sq_count), (i < 3) ? 32'(i + 1) : 32'd4);
      end
      check("t3_full", 32'(sq_full), 32'd1);
      idle(4);
      check("t3_empty", 32'(sq_count), 32'd0);
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 9'(i * 4), 32'h0, 3'b010, 0, 0);
         check("t3_lw", rd_data, 32'(i + 1));
         tick();
      end

      // 4: misaligned accesses
      drive(1, 0, 9'h011, 32'h0, 3'b001, 0, 0); check("t4_lh", rd_data, 32'd0); tick();
      check("t4_mis", 32'(misaligned), 32'd1);
      drive(0, 1, 9'h002, 32'h1, 3'b010, 0, 0); tick();
      drive(1, 0, 9'h000, 32'h0, 3'b010, 0, 0); check("t4_lw", rd_data, 32'd1); tick();
      idle(5);
      check("t4_sticky", 32'(misaligned), 32'd1);

      // 5: reset discards pending stores
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 9'(9'h040 + i * 4), 32'h11111111 * (i + 1), 3'b010, 0, 0);
         tick();
      end
      drive(0, 0, 9'h0, 32'h0, 3'b010, 0, 1); tick();
      check("t5_cnt", 32'(sq_count), 32'd0);
      check("t5_mis", 32'(misaligned), 32'd0);
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 9'(9'h040 + i * 4), 32'h0, 3'b010, 0, 0);
         check("t5_lw", rd_data, 32'd0);
         tick();
      end

      // 6: flush under continuous load traffic
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 9'(9'h050 + i * 4), 32'hA5A50000 + 32'(i), 3'b010, 0, 0);
         tick();
      end
      for (int c = 0; c < 6; c++) begin
         drive(1, 0, 9'(9'h050 + (c % 3) * 4), 32'h0, 3'b010, 1, 0);
         check("t6_done", 32'(flush_done), 32'(c >= 3));
         check("t6_lw", rd_data, 32'hA5A50000 + 32'(c % 3));
         tick();
      end

      // Random traffic over a small window so forwarding and partial overlaps are frequent
      for (int c = 0; c < 4000; c++) begin
         int p;
         bit r, w, fl, rst;
         logic [2:0] f;
         logic [8:0] a;
         p   = int'($urandom_range(0, 99));
         r   = (p < 45);
         w   = (p >= 38 && p < 80);
         fl  = ($urandom_range(0, 15) == 0);
         rst = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 9) == 0) f = 3'($urandom_range(0, 7));
         else begin
            case ($urandom_range(0, 4))
               0: f = 3'b000;
               1: f = 3'b001;
               2: f = 3'b010;
               3: f = 3'b100;
               default: f = 3'b101;
            endcase
         end
         a = 9'($urandom_range(0, 31));
         if ($urandom_range(0, 19) != 0) a = a & ~9'(nbytes(f) - 1);
         drive(r, w, a, $urandom, f, fl, rst);
         tick();
      end
      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
